// File: rtl/stream_downsizer.sv
// Splits each wide word into 1..RATIO narrow beats, LSB slice first, flagging the last beat; 1-cycle accept-to-beat0 latency.
// Backpressure: beat held stable while out_ready_i is low; in_ready_o in SEND follows out_ready_i on the last beat so words chain without bubbles.
module stream_downsizer #(
    parameter int WIDE_WIDTH = 64,
    parameter int RATIO      = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clr_i,
    input  logic [WIDE_WIDTH-1:0]              in_data_i,
    input  logic [$clog2(RATIO)-1:0]           in_len_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    output logic [WIDE_WIDTH/RATIO-1:0]        out_data_o,
    output logic                               out_last_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic                               busy_o
);
    localparam int NARROW_WIDTH = WIDE_WIDTH / RATIO;
    localparam int LEN_WIDTH    = $clog2(RATIO);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [WIDE_WIDTH-1:0]   word_q, word_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    idx_q, idx_d;
    logic                    send;
    logic                    in_hs;
    logic                    out_hs;

    always_comb begin
        send        = (state_q == SEND);
        out_valid_o = send;
        busy_o      = send;
        out_last_o  = send && (idx_q == len_q);
        in_ready_o  = !rst_i && !clr_i && (!send || (out_last_o && out_ready_i));
        in_hs       = in_valid_i && in_ready_o;
        out_hs      = out_valid_o && out_ready_i;
    end

    // Beat mux straight from the held word; not gated by valid.
    always_comb begin
        out_data_o = word_q[NARROW_WIDTH-1:0];
        for (int k = 0; k < RATIO; k++) begin
            if (idx_q == LEN_WIDTH'(k)) begin
                out_data_o = word_q[k*NARROW_WIDTH +: NARROW_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        len_d   = len_q;
        idx_d   = idx_q;
        if (clr_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            if (out_hs) begin
                if (out_last_o) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + LEN_WIDTH'(1);
                end
            end
            // A load on the last-beat handshake overrides the drop to IDLE.
            if (in_hs) begin
                word_d  = in_data_i;
                len_d   = in_len_i;
                idx_d   = '0;
                state_d = SEND;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_stream_downsizer.sv
// Scoreboard bench for stream_downsizer (64-bit in, 4 x 16-bit beats).
module tb_stream_downsizer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clr_i;
    logic [63:0] in_data_i;
    logic [1:0]  in_len_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] out_data_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb_q[$];

    stream_downsizer #(.WIDE_WIDTH(64), .RATIO(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .in_data_i  (in_data_i),
        .in_len_i   (in_len_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void exp_beat(input logic [15:0] d, input logic l);
        sb_q.push_back({l, d});
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: pops one expected beat per output handshake, checks stall stability.
    logic        stall_prev = 1'b0;
    logic [16:0] stall_val;
    always @(negedge clk_i) begin
        if (stall_prev && out_valid_o === 1'b1) begin
            chk("stall_stable", {47'd0, out_last_o, out_data_o}, {47'd0, stall_val});
        end
        stall_prev = (out_valid_o === 1'b1) && !out_ready_i && !clr_i && !rst_i;
        stall_val  = {out_last_o, out_data_o};
        if (out_valid_o === 1'b1 && out_ready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h last %b expected none", out_data_o, out_last_o);
            end else begin
                chk("beat", {47'd0, out_last_o, out_data_o}, {47'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input logic [1:0] l);
        int n = 0;
        in_data_i  = d;
        in_len_i   = l;
        in_valid_i = 1'b1;
        #1;
        while (!in_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 20 cycles");
        end
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic full_word(input string tag);
        out_ready_i = 1'b1;
        exp_beat(16'h2211, 1'b0);
        exp_beat(16'h4433, 1'b0);
        exp_beat(16'h6655, 1'b0);
        exp_beat(16'h8877, 1'b1);
        send_word(64'h8877_6655_4433_2211, 2'd3);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_valid"}, {63'd0, out_valid_o}, 64'd1);
            chk({tag, "_last"}, {63'd0, out_last_o}, (i == 3) ? 64'd1 : 64'd0);
            tick();
        end
        chk({tag, "_idle_valid"}, {63'd0, out_valid_o}, 64'd0);
        chk({tag, "_idle_busy"}, {63'd0, busy_o}, 64'd0);
        chk({tag, "_idle_ready"}, {63'd0, in_ready_o}, 64'd1);
    endtask

    // Words A (len 1) and B (len 2) offered back to back; pat[c-1] is out_ready in cycle c.
    task automatic run_ab(input logic [6:0] pat, input int ncyc, input int exp_b);
        int w = 0;
        int b_at = -1;
        int nhs = 0;
        exp_beat(16'hA0A0, 1'b0);
        exp_beat(16'hA1A1, 1'b1);
        exp_beat(16'hB0B0, 1'b0);
        exp_beat(16'hB1B1, 1'b0);
        exp_beat(16'hB2B2, 1'b1);
        for (int c = 0; c <= ncyc; c++) begin
            out_ready_i = (c == 0) ? 1'b1 : pat[c-1];
            in_valid_i  = (w < 2);
            in_data_i   = (w == 0) ? 64'hFFFF_FFFF_A1A1_A0A0 : 64'hFFFF_B2B2_B1B1_B0B0;
            in_len_i    = (w == 0) ? 2'd1 : 2'd2;
            #1;
            if (out_valid_o && out_ready_i) nhs++;
            if (in_valid_i && in_ready_o) begin
                if (w == 1) b_at = c;
                w++;
            end
            @(posedge clk_i);
            #1;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        chk("ab_beat_count", nhs, 5);
        chk("ab_b_accept_cycle", b_at, exp_b);
        chk("ab_done_valid", {63'd0, out_valid_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b1;
        clr_i       = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 64'h1234_5678_9ABC_DEF0;
        in_len_i    = 2'd1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_in_ready", {63'd0, in_ready_o}, 64'd0);
            chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        end
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("rel_in_ready", {63'd0, in_ready_o}, 64'd1);
        chk("rel_busy", {63'd0, busy_o}, 64'd0);
        chk("rel_last", {63'd0, out_last_o}, 64'd0);
        chk("rel_data", {48'd0, out_data_o}, 64'd0);
        tick();

        full_word("full");

        exp_beat(16'hABCD, 1'b1);
        send_word(64'hFFFF_FFFF_FFFF_ABCD, 2'd0);
        chk("short_valid", {63'd0, out_valid_o}, 64'd1);
        chk("short_last", {63'd0, out_last_o}, 64'd1);
        tick();
        chk("short_idle", {63'd0, out_valid_o}, 64'd0);
        tick();

        run_ab(7'b1101101, 7, 3);
        tick();
        run_ab(7'b1111111, 5, 2);
        tick();

        // Flush coinciding with the beat-1 handshake: beat 1 still counts, beats 2-3 vanish.
        exp_beat(16'h1111, 1'b0);
        exp_beat(16'h2222, 1'b0);
        out_ready_i = 1'b1;
        send_word(64'h4444_3333_2222_1111, 2'd3);
        tick();
        clr_i      = 1'b1;
        in_valid_i = 1'b1;
        #1;
        chk("clr_in_ready", {63'd0, in_ready_o}, 64'd0);
        tick();
        clr_i      = 1'b0;
        in_valid_i = 1'b0;
        chk("clr_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("clr_busy", {63'd0, busy_o}, 64'd0);
        exp_beat(16'h5555, 1'b0);
        exp_beat(16'h6666, 1'b1);
        send_word(64'h0000_0000_6666_5555, 2'd1);
        tick();
        tick();
        chk("post_clr_idle", {63'd0, out_valid_o}, 64'd0);

        // Reset during beat 2 (not accepted downstream).
        exp_beat(16'h5151, 1'b0);
        exp_beat(16'h6262, 1'b0);
        send_word(64'h8484_7373_6262_5151, 2'd3);
        tick();
        tick();
        rst_i       = 1'b1;
        out_ready_i = 1'b0;
        #1;
        chk("rstmid_valid_held", {63'd0, out_valid_o}, 64'd1);
        chk("rstmid_in_ready", {63'd0, in_ready_o}, 64'd0);
        tick();
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        chk("rstmid_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rstmid_busy", {63'd0, busy_o}, 64'd0);
        chk("rstmid_data_zero", {48'd0, out_data_o}, 64'd0);
        full_word("after_rst");

        tick();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
